fp_addsub_pipe: RTL



---
 rtl/fp_addsub_pipe.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor (align, add, normalise, round/pack)
// with round-to-nearest-even, flush-to-zero denormals and a valid/ready stream with global stall.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   exception,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int SIG_W  = MAN_W + 4;
    localparam int SUM_W  = MAN_W + 5;
    localparam int EXPS_W = EXP_W + 2;
    localparam int LZC_W  = $clog2(SIG_W + 1);
    localparam logic [31:0] SH_MAX = 32'(MAN_W + 3);
    localparam logic [EXP_W:0] EXP_ALL1 = {1'b0, {EXP_W{1'b1}}};

    logic en;
    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    // ---------------- S1: swap and align ----------------
    logic                a_s, b_raw_s, b_s, a_zero, b_zero, swap, x_s, y_s, sticky, exc_in;
    logic [EXP_W-1:0]    a_e, b_e, x_e, y_e, diff;
    logic [MAN_W-1:0]    a_f, b_f;
    logic [MAN_W:0]      a_sig, b_sig, x_sig, y_sig;
    logic [31:0]         diff_w, sh;
    logic [SIG_W-1:0]    y_ext, y_al;

    assign {a_s, a_e, a_f}     = a;
    assign {b_raw_s, b_e, b_f} = b;
    assign b_s    = b_raw_s ^ sub;
    assign a_zero = (a_e == '0);
    assign b_zero = (b_e == '0);
    assign a_sig  = a_zero ? '0 : {1'b1, a_f};
    assign b_sig  = b_zero ? '0 : {1'b1, b_f};
    assign exc_in = (a_e == '1) | (b_e == '1);
    assign swap   = {b_e, b_sig[MAN_W-1:0]} > {a_e, a_sig[MAN_W-1:0]};
    assign x_s    = swap ? b_s   : a_s;
    assign y_s    = swap ? a_s   : b_s;
    assign x_e    = swap ? b_e   : a_e;
    assign y_e    = swap ? a_e   : b_e;
    assign x_sig  = swap ? b_sig : a_sig;
    assign y_sig  = swap ? a_sig : b_sig;
    assign diff   = x_e - y_e;
    assign diff_w = 32'(diff);
    assign sh     = (diff_w > SH_MAX) ? SH_MAX : diff_w;
    assign y_ext  = {y_sig, 3'b000};
    // Everything shifted past the sticky position still has to influence rounding.
    assign sticky = |(y_ext & ~({SIG_W{1'b1}} << sh));
    assign y_al   = (y_ext >> sh) | {{(SIG_W-1){1'b0}}, sticky};

    logic                s1_valid_reg, s1_sign_reg, s1_eff_sub_reg, s1_exc_reg, s1_zsign_reg;
    logic [EXP_W-1:0]    s1_exp_reg;
    logic [SIG_W-1:0]    s1_x_reg, s1_y_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_sign_reg    <= 1'b0;
            s1_eff_sub_reg <= 1'b0;
            s1_exc_reg     <= 1'b0;
            s1_zsign_reg   <= 1'b0;
            s1_exp_reg     <= '0;
            s1_x_reg       <= '0;
            s1_y_reg       <= '0;
        end else if (en) begin
            s1_valid_reg   <= in_valid;
            s1_sign_reg    <= x_s;
            s1_eff_sub_reg <= x_s ^ y_s;
            s1_exc_reg     <= exc_in;
            // A zero sum is negative only when both operands are negative zeros.
            s1_zsign_reg   <= x_s & y_s;
            s1_exp_reg     <= x_e;
            s1_x_reg       <= {x_sig, 3'b000};
            s1_y_reg       <= y_al;
        end
    end

    // ---------------- S2: add / subtract ----------------
    logic [SUM_W-1:0] sum;
    assign sum = s1_eff_sub_reg ? ({1'b0, s1_x_reg} - {1'b0, s1_y_reg})
                                : ({1'b0, s1_x_reg} + {1'b0, s1_y_reg});

    logic                s2_valid_reg, s2_sign_reg, s2_exc_reg, s2_zsign_reg;
    logic [EXP_W-1:0]    s2_exp_reg;
    logic [SUM_W-1:0]    s2_sum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_sign_reg  <= 1'b0;
            s2_exc_reg   <= 1'b0;
            s2_zsign_reg <= 1'b0;
            s2_exp_reg   <= '0;
            s2_sum_reg   <= '0;
        end else if (en) begin
            s2_valid_reg <= s1_valid_reg;
            s2_sign_reg  <= s1_sign_reg;
            s2_exc_reg   <= s1_exc_reg;
            s2_zsign_reg <= s1_zsign_reg;
            s2_exp_reg   <= s1_exp_reg;
            s2_sum_reg   <= sum;
        end
    end

    // ---------------- S3: normalise ----------------
    logic [LZC_W-1:0]  lzc;
    logic              found;
    logic [SIG_W-1:0]  norm;
    logic [EXPS_W-1:0] exp_n;

    always_comb begin
        lzc   = '0;
        found = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (!found && s2_sum_reg[i]) begin
                lzc   = LZC_W'(SIG_W - 1 - i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        if (s2_sum_reg[SUM_W-1]) begin
            norm  = {s2_sum_reg[SUM_W-1:2], s2_sum_reg[1] | s2_sum_reg[0]};
            exp_n = {2'b00, s2_exp_reg} + EXPS_W'(1);
        end else begin
            norm  = s2_sum_reg[SIG_W-1:0] << lzc;
            exp_n = {2'b00, s2_exp_reg} - EXPS_W'(lzc);
        end
    end

    logic                s3_valid_reg, s3_sign_reg, s3_exc_reg, s3_zsign_reg, s3_zero_reg;
    logic [EXPS_W-1:0]   s3_exp_reg;
    logic [SIG_W-1:0]    s3_norm_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid_reg <= 1'b0;
            s3_sign_reg  <= 1'b0;
            s3_exc_reg   <= 1'b0;
            s3_zsign_reg <= 1'b0;
            s3_zero_reg  <= 1'b0;
            s3_exp_reg   <= '0;
            s3_norm_reg  <= '0;
        end else if (en) begin
            s3_valid_reg <= s2_valid_reg;
            s3_sign_reg  <= s2_sign_reg;
            s3_exc_reg   <= s2_exc_reg;
            s3_zsign_reg <= s2_zsign_reg;
            s3_zero_reg  <= (s2_sum_reg == '0);
            s3_exp_reg   <= exp_n;
            s3_norm_reg  <= norm;
        end
    end

    // ---------------- S4: round and pack ----------------
    logic                rnd, rcarry, exp_neg, ovf_c, unf_c;
    logic [MAN_W+1:0]    mant;
    logic [MAN_W-1:0]    frac_f;
    logic [EXPS_W-1:0]   exp_f;
    logic [EXP_W+MAN_W:0] res_next;
    logic                exc_next, ovf_next, unf_next;

    assign rnd     = s3_norm_reg[2] & (s3_norm_reg[1] | s3_norm_reg[0] | s3_norm_reg[3]);
    assign mant    = {1'b0, s3_norm_reg[SIG_W-1:3]} + (MAN_W+2)'(rnd);
    assign rcarry  = mant[MAN_W+1];
    assign frac_f  = rcarry ? mant[MAN_W:1] : mant[MAN_W-1:0];
    assign exp_f   = s3_exp_reg + EXPS_W'(rcarry);
    assign exp_neg = exp_f[EXPS_W-1];
    assign ovf_c   = !exp_neg && (exp_f[EXPS_W-2:0] >= EXP_ALL1);
    assign unf_c   = exp_neg || (exp_f == '0);

    always_comb begin
        res_next = {s3_sign_reg, exp_f[EXP_W-1:0], frac_f};
        exc_next = 1'b0;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (s3_exc_reg) begin
            res_next = '1;
            exc_next = 1'b1;
        end else if (s3_zero_reg) begin
            res_next = {s3_zsign_reg, {(EXP_W+MAN_W){1'b0}}};
        end else if (ovf_c) begin
            res_next = {s3_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_next = 1'b1;
        end else if (unf_c) begin
            res_next = {s3_sign_reg, {(EXP_W+MAN_W){1'b0}}};
            unf_next = 1'b1;
        end
    end

    logic                 out_valid_reg, exc_reg, ovf_reg, unf_reg;
    logic [EXP_W+MAN_W:0] result_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            exc_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
            unf_reg       <= 1'b0;
        end else if (en) begin
            out_valid_reg <= s3_valid_reg;
            result_reg    <= res_next;
            exc_reg       <= exc_next;
            ovf_reg       <= ovf_next;
            unf_reg       <= unf_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign exception = exc_reg;
    assign overflow  = ovf_reg;
    assign underflow = unf_reg;
endmodule
